// File: rtl/can_host_bus_if_if.sv
// Bus bundle between the local processor, the host bus interface and the
// CAN register bank: host request/response signals plus register-side strobes.
interface can_host_bus_if_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
);
   logic                  host_cs;
   logic                  host_wr;
   logic                  host_rd;
   logic [ADDR_WIDTH-1:0] host_addr;
   logic [DATA_WIDTH-1:0] host_wdata;
   logic [DATA_WIDTH-1:0] host_rdata;
   logic                  host_ack;
   logic                  host_err;
   logic [ADDR_WIDTH-1:0] reg_addr;
   logic [DATA_WIDTH-1:0] reg_wdata;
   logic                  reg_we;
   logic                  reg_re;
   logic [DATA_WIDTH-1:0] reg_rdata;

   // slave: the bus interface block; master: the processor plus register bank
   modport slave (
      input  host_cs, host_wr, host_rd, host_addr, host_wdata, reg_rdata,
      output host_rdata, host_ack, host_err, reg_addr, reg_wdata, reg_we, reg_re
   );

   modport master (
      output host_cs, host_wr, host_rd, host_addr, host_wdata, reg_rdata,
      input  host_rdata, host_ack, host_err, reg_addr, reg_wdata, reg_we, reg_re
   );
endinterface

// File: rtl/can_host_bus_if.sv
// Host-side bus interface for the CAN register file: turns level-held host
// requests into registered address/data plus one-cycle reg_we/reg_re pulses.
module can_host_bus_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8,
   parameter int RD_WAIT    = 2,
   parameter int U_DLY      = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   can_host_bus_if_if.slave        bus,
   output logic [2:0]              state_o
);

   // Handshake: a request is held (host_cs plus one strobe) until host_ack
   // rises; host_ack then stays high until host_cs is seen low, after which
   // one dead HOLD cycle passes before the next request can be sampled.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WRITE = 3'd1,
      ST_READ  = 3'd2,
      ST_ACK   = 3'd3,
      ST_HOLD  = 3'd4
   } state_e;

   localparam logic [3:0] RdWaitInit = 4'(RD_WAIT);

   // Registers here are zero-delay; U_DLY is accepted only so existing
   // integrations that pass it keep elaborating.
   if (U_DLY > 0) begin : g_udly_accepted
   end

   state_e                state_q;
   logic [3:0]            cnt_q;
   logic [ADDR_WIDTH-1:0] reg_addr_q;
   logic [DATA_WIDTH-1:0] reg_wdata_q;
   logic [DATA_WIDTH-1:0] host_rdata_q;
   logic                  host_ack_q;
   logic                  host_err_q;
   logic                  reg_we_q;
   logic                  reg_re_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 4'd0;
         reg_addr_q   <= '0;
         reg_wdata_q  <= '0;
         host_rdata_q <= '0;
         host_ack_q   <= 1'b0;
         host_err_q   <= 1'b0;
         reg_we_q     <= 1'b0;
         reg_re_q     <= 1'b0;
      end else begin
         reg_we_q <= 1'b0;
         reg_re_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (bus.host_cs) begin
                  if (bus.host_wr && !bus.host_rd) begin
                     reg_addr_q  <= bus.host_addr;
                     reg_wdata_q <= bus.host_wdata;
                     reg_we_q    <= 1'b1;
                     state_q     <= ST_WRITE;
                  end else if (bus.host_rd && !bus.host_wr) begin
                     reg_addr_q <= bus.host_addr;
                     cnt_q      <= RdWaitInit;
                     reg_re_q   <= 1'b1;
                     state_q    <= ST_READ;
                  end else if (bus.host_rd && bus.host_wr) begin
                     // Conflicting strobes: flag and acknowledge without touching registers
                     host_err_q <= 1'b1;
                     host_ack_q <= 1'b1;
                     state_q    <= ST_ACK;
                  end
               end
            end
            ST_WRITE: begin
               host_ack_q <= 1'b1;
               state_q    <= ST_ACK;
            end
            ST_READ: begin
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  host_rdata_q <= bus.reg_rdata;
                  host_ack_q   <= 1'b1;
                  state_q      <= ST_ACK;
               end
            end
            ST_ACK: begin
               if (!bus.host_cs) begin
                  host_ack_q <= 1'b0;
                  state_q    <= ST_HOLD;
               end
            end
            ST_HOLD: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.host_rdata = host_rdata_q;
   assign bus.host_ack   = host_ack_q;
   assign bus.host_err   = host_err_q;
   assign bus.reg_addr   = reg_addr_q;
   assign bus.reg_wdata  = reg_wdata_q;
   assign bus.reg_we     = reg_we_q;
   assign bus.reg_re     = reg_re_q;
   assign state_o        = state_q;

endmodule

// File: tb/tb_can_host_bus_if.sv
// Directed bench for can_host_bus_if: write, read, back-to-back, error,
// reset mid-read and the RD_WAIT extremes on three instances.
module tb_can_host_bus_if;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   we_cnt2 = 0;
   int   re_cnt2 = 0;
   int   re_cnt1 = 0;
   int   re_cnt15 = 0;
   logic [2:0] st2, st1, st15;

   always #5 clk = ~clk;

   can_host_bus_if_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) b2 ();
   can_host_bus_if_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) b1 ();
   can_host_bus_if_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) b15 ();

   can_host_bus_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .RD_WAIT(2), .U_DLY(1)) u_dut (
      .clk(clk), .rst(rst), .bus(b2), .state_o(st2));
   can_host_bus_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .RD_WAIT(1), .U_DLY(1)) u_dut1 (
      .clk(clk), .rst(rst), .bus(b1), .state_o(st1));
   can_host_bus_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .RD_WAIT(15), .U_DLY(1)) u_dut15 (
      .clk(clk), .rst(rst), .bus(b15), .state_o(st15));

   // Pulse counters sampled mid-cycle
   always @(negedge clk) begin
      if (b2.reg_we === 1'b1) we_cnt2++;
      if (b2.reg_re === 1'b1) re_cnt2++;
      if (b1.reg_re === 1'b1) re_cnt1++;
      if (b15.reg_re === 1'b1) re_cnt15++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      b2.host_cs = 0;  b2.host_wr = 0;  b2.host_rd = 0;
      b2.host_addr = 0; b2.host_wdata = 0; b2.reg_rdata = 0;
      b1.host_cs = 0;  b1.host_wr = 0;  b1.host_rd = 0;
      b1.host_addr = 0; b1.host_wdata = 0; b1.reg_rdata = 0;
      b15.host_cs = 0; b15.host_wr = 0; b15.host_rd = 0;
      b15.host_addr = 0; b15.host_wdata = 0; b15.reg_rdata = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(); step();
      checks++;
      if ({b2.host_rdata, b2.host_ack, b2.host_err, b2.reg_addr, b2.reg_wdata, b2.reg_we, b2.reg_re} !== 28'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %h expected 0",
                  {b2.host_rdata, b2.host_ack, b2.host_err, b2.reg_addr, b2.reg_wdata, b2.reg_we, b2.reg_re});
      end
      checks++;
      if (st2 !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", st2); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_write();
      int base;
      base = we_cnt2;
      b2.host_cs = 1; b2.host_wr = 1; b2.host_addr = 8'h05; b2.host_wdata = 8'hA5;
      step();
      checks++;
      if ({b2.reg_we, b2.reg_addr, b2.reg_wdata, b2.host_ack} !== {1'b1, 8'h05, 8'hA5, 1'b0}) begin
         errors++;
         $display("FAIL write_pulse: got we=%b addr=%h wdata=%h ack=%b expected we=1 addr=05 wdata=a5 ack=0",
                  b2.reg_we, b2.reg_addr, b2.reg_wdata, b2.host_ack);
      end
      step();
      checks++;
      if ({b2.reg_we, b2.host_ack} !== 2'b01) begin
         errors++; $display("FAIL write_ack: got we=%b ack=%b expected we=0 ack=1", b2.reg_we, b2.host_ack);
      end
      step(); step();
      checks++;
      if (b2.host_ack !== 1'b1) begin errors++; $display("FAIL write_ack_held: got %b expected 1", b2.host_ack); end
      b2.host_cs = 0; b2.host_wr = 0;
      step();
      checks++;
      if ({b2.host_ack, st2} !== {1'b0, 3'd4}) begin
         errors++; $display("FAIL write_release: got ack=%b state=%0d expected ack=0 state=4", b2.host_ack, st2);
      end
      step();
      checks++;
      if (we_cnt2 - base !== 1) begin errors++; $display("FAIL write_pulse_count: got %0d expected 1", we_cnt2 - base); end
      checks++;
      if ({st2, b2.reg_addr, b2.reg_wdata} !== {3'd0, 8'h05, 8'hA5}) begin
         errors++; $display("FAIL write_hold_regs: got state=%0d addr=%h wdata=%h expected 0 05 a5", st2, b2.reg_addr, b2.reg_wdata);
      end
   endtask

   task automatic test_read();
      int base;
      base = re_cnt2;
      b2.host_cs = 1; b2.host_rd = 1; b2.host_addr = 8'h12; b2.reg_rdata = 8'h3C;
      step();
      checks++;
      if ({b2.reg_re, b2.reg_addr, b2.host_ack} !== {1'b1, 8'h12, 1'b0}) begin
         errors++; $display("FAIL read_pulse: got re=%b addr=%h ack=%b expected re=1 addr=12 ack=0", b2.reg_re, b2.reg_addr, b2.host_ack);
      end
      step();
      checks++;
      if ({b2.reg_re, b2.host_ack} !== 2'b00) begin
         errors++; $display("FAIL read_wait: got re=%b ack=%b expected 0 0", b2.reg_re, b2.host_ack);
      end
      step();
      checks++;
      if ({b2.host_ack, b2.host_rdata} !== {1'b1, 8'h3C}) begin
         errors++; $display("FAIL read_ack: got ack=%b rdata=%h expected ack=1 rdata=3c", b2.host_ack, b2.host_rdata);
      end
      b2.reg_rdata = 8'hFF;
      step();
      checks++;
      if (b2.host_rdata !== 8'h3C) begin errors++; $display("FAIL read_rdata_stable: got %h expected 3c", b2.host_rdata); end
      b2.host_cs = 0; b2.host_rd = 0;
      step(); step();
      checks++;
      if (re_cnt2 - base !== 1) begin errors++; $display("FAIL read_pulse_count: got %0d expected 1", re_cnt2 - base); end
   endtask

   task automatic test_back_to_back();
      int wbase;
      int rbase;
      wbase = we_cnt2;
      rbase = re_cnt2;
      b2.host_cs = 1; b2.host_wr = 1; b2.host_addr = 8'h20; b2.host_wdata = 8'h11;
      repeat (5) step();
      checks++;
      if ({b2.host_ack, 32'(we_cnt2 - wbase)} !== {1'b1, 32'd1}) begin
         errors++; $display("FAIL b2b_write_once: got ack=%b pulses=%0d expected ack=1 pulses=1", b2.host_ack, we_cnt2 - wbase);
      end
      b2.host_wr = 0; b2.host_rd = 1; b2.host_addr = 8'h21; b2.reg_rdata = 8'h5A;
      step(); step();
      checks++;
      if ({b2.reg_re, b2.host_ack, 32'(re_cnt2 - rbase)} !== {1'b0, 1'b1, 32'd0}) begin
         errors++; $display("FAIL b2b_busy_ignored: got re=%b ack=%b re_pulses=%0d expected 0 1 0", b2.reg_re, b2.host_ack, re_cnt2 - rbase);
      end
      b2.host_cs = 0;
      step();
      checks++;
      if ({b2.host_ack, st2} !== {1'b0, 3'd4}) begin
         errors++; $display("FAIL b2b_hold: got ack=%b state=%0d expected 0 4", b2.host_ack, st2);
      end
      b2.host_cs = 1;
      step();
      checks++;
      if ({b2.reg_re, st2} !== {1'b0, 3'd0}) begin
         errors++; $display("FAIL b2b_dead_cycle: got re=%b state=%0d expected 0 0", b2.reg_re, st2);
      end
      step();
      checks++;
      if ({b2.reg_re, b2.reg_addr} !== {1'b1, 8'h21}) begin
         errors++; $display("FAIL b2b_resample: got re=%b addr=%h expected 1 21", b2.reg_re, b2.reg_addr);
      end
      step(); step();
      checks++;
      if ({b2.host_ack, b2.host_rdata} !== {1'b1, 8'h5A}) begin
         errors++; $display("FAIL b2b_read_ack: got ack=%b rdata=%h expected 1 5a", b2.host_ack, b2.host_rdata);
      end
      b2.host_cs = 0; b2.host_rd = 0;
      step(); step();
   endtask

   task automatic test_error();
      int wbase;
      int rbase;
      wbase = we_cnt2;
      rbase = re_cnt2;
      b2.host_cs = 1; b2.host_wr = 1; b2.host_rd = 1; b2.host_addr = 8'h30; b2.host_wdata = 8'hEE;
      step();
      checks++;
      if ({b2.host_err, b2.host_ack, st2, b2.host_rdata} !== {1'b1, 1'b1, 3'd3, 8'h5A}) begin
         errors++; $display("FAIL err_flag: got err=%b ack=%b state=%0d rdata=%h expected 1 1 3 5a",
                            b2.host_err, b2.host_ack, st2, b2.host_rdata);
      end
      step();
      b2.host_cs = 0; b2.host_wr = 0; b2.host_rd = 0;
      step(); step();
      checks++;
      if ({32'(we_cnt2 - wbase), 32'(re_cnt2 - rbase), b2.reg_addr} !== {32'd0, 32'd0, 8'h21}) begin
         errors++; $display("FAIL err_no_access: got we=%0d re=%0d addr=%h expected 0 0 21", we_cnt2 - wbase, re_cnt2 - rbase, b2.reg_addr);
      end
      b2.host_cs = 1; b2.host_wr = 1; b2.host_addr = 8'h44; b2.host_wdata = 8'h99;
      step(); step();
      checks++;
      if ({b2.host_err, b2.host_ack, b2.reg_wdata, 32'(we_cnt2 - wbase)} !== {1'b1, 1'b1, 8'h99, 32'd1}) begin
         errors++; $display("FAIL err_sticky: got err=%b ack=%b wdata=%h we=%0d expected 1 1 99 1",
                            b2.host_err, b2.host_ack, b2.reg_wdata, we_cnt2 - wbase);
      end
      b2.host_cs = 0; b2.host_wr = 0;
      step(); step();
   endtask

   task automatic test_reset_mid_read();
      b2.host_cs = 1; b2.host_rd = 1; b2.host_addr = 8'h33; b2.reg_rdata = 8'h77;
      step();
      checks++;
      if (b2.reg_re !== 1'b1) begin errors++; $display("FAIL rst_read_start: got re=%b expected 1", b2.reg_re); end
      rst = 1'b1;
      step();
      checks++;
      if ({b2.host_ack, b2.reg_re, b2.host_rdata, b2.host_err, st2} !== {1'b0, 1'b0, 8'h00, 1'b0, 3'd0}) begin
         errors++; $display("FAIL rst_abort: got ack=%b re=%b rdata=%h err=%b state=%0d expected 0 0 00 0 0",
                            b2.host_ack, b2.reg_re, b2.host_rdata, b2.host_err, st2);
      end
      rst = 1'b0;
      step();
      checks++;
      if ({b2.reg_re, b2.reg_addr} !== {1'b1, 8'h33}) begin
         errors++; $display("FAIL rst_fresh_read: got re=%b addr=%h expected 1 33", b2.reg_re, b2.reg_addr);
      end
      step(); step();
      checks++;
      if ({b2.host_ack, b2.host_rdata} !== {1'b1, 8'h77}) begin
         errors++; $display("FAIL rst_fresh_ack: got ack=%b rdata=%h expected 1 77", b2.host_ack, b2.host_rdata);
      end
      b2.host_cs = 0; b2.host_rd = 0;
      step(); step();
   endtask

   task automatic test_rd_wait_min();
      int base;
      int k;
      base = re_cnt1;
      k = 0;
      b1.host_cs = 1; b1.host_rd = 1; b1.host_addr = 8'h01; b1.reg_rdata = 8'h6B;
      while (b1.host_ack !== 1'b1 && k < 40) begin step(); k++; end
      checks++;
      if ({32'(k), b1.host_rdata} !== {32'd2, 8'h6B}) begin
         errors++; $display("FAIL rd_wait1_latency: got cycles=%0d rdata=%h expected 2 6b", k, b1.host_rdata);
      end
      b1.host_cs = 0; b1.host_rd = 0;
      step(); step();
      checks++;
      if (re_cnt1 - base !== 1) begin errors++; $display("FAIL rd_wait1_pulses: got %0d expected 1", re_cnt1 - base); end
   endtask

   task automatic test_rd_wait_max();
      int base;
      int k;
      base = re_cnt15;
      k = 0;
      b15.host_cs = 1; b15.host_rd = 1; b15.host_addr = 8'h7F; b15.reg_rdata = 8'hC3;
      while (b15.host_ack !== 1'b1 && k < 40) begin step(); k++; end
      checks++;
      if ({32'(k), b15.host_rdata} !== {32'd16, 8'hC3}) begin
         errors++; $display("FAIL rd_wait15_latency: got cycles=%0d rdata=%h expected 16 c3", k, b15.host_rdata);
      end
      b15.host_cs = 0; b15.host_rd = 0;
      step(); step();
      checks++;
      if (re_cnt15 - base !== 1) begin errors++; $display("FAIL rd_wait15_pulses: got %0d expected 1", re_cnt15 - base); end
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_write();
      test_read();
      test_back_to_back();
      test_error();
      test_reset_mid_read();
      test_rd_wait_min();
      test_rd_wait_max();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
